branch_commit_reporter: RTL and testbench

- Sits between ROB commit and the branch predictor.
- Accepts one committed conditional branch per cycle (pc, predicted direction, resolved direction, target) and queues it in a small FIFO.
- Drains the FIFO into the predictor's update port (rob_in_en / rob_ain / rob_jump), one update per cycle.
- On a direction mispredict, issues a one-cycle flush pulse with the corrected fetch PC.

---
 rtl/branch_commit_reporter_pkg.sv | 42 ++++
 rtl/branch_commit_reporter_if.sv | 65 ++++++
 rtl/branch_commit_reporter_fifo.sv | 86 ++++++++
 rtl/branch_commit_reporter.sv | 133 +++++++++++++
 tb/tb_branch_commit_reporter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_commit_reporter_pkg.sv
// ---------------------------------------------------------------------------
// branch_commit_reporter_pkg
//
// Shared constants and small helpers for the branch commit reporter slice.
//
//   ADDR_WIDTH          default PC / address width
//   BCR_QDEPTH          default update FIFO depth (power of 2, >= 2)
//   BCR_CNT_WIDTH       default statistics counter width
//   BCR_ENTRY_JUMP_BIT  bit position of the resolved direction in an entry
//   BCR_ENTRY_PC_LSB    lowest bit of the PC field in an entry
//
// An update FIFO entry is packed as {pc, jump}: the resolved direction sits
// in bit 0 and the PC occupies the bits above it.
//
// Optional feature macro used by this slice: BRANCH_COMMIT_STATS_EN
// ---------------------------------------------------------------------------
package branch_commit_reporter_pkg;

    localparam int ADDR_WIDTH         = 32;
    localparam int BCR_QDEPTH         = 4;
    localparam int BCR_CNT_WIDTH      = 32;

    localparam int BCR_ENTRY_JUMP_BIT = 0;
    localparam int BCR_ENTRY_PC_LSB   = 1;

    // Width of one packed {pc, jump} entry.
    function automatic int bcr_entry_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // Pointer width for a power-of-2 FIFO; never allowed to collapse to 0.
    function automatic int bcr_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // A direction mispredict is any disagreement between fetch and resolve.
    function automatic logic bcr_is_mispredict(input logic pred_jump,
                                               input logic jump);
        return pred_jump != jump;
    endfunction

endpackage

// File: rtl/branch_commit_reporter_if.sv
// ---------------------------------------------------------------------------
// branch_commit_reporter_if
//
// Bundles the commit-side and predictor-side signals of the branch commit
// reporter.
//
//   Commit side   : cmt_en, cmt_pc, cmt_pred_jump, cmt_jump, cmt_target,
//                   cmt_ready
//   Update side   : rob_in_en, rob_ain, rob_jump, upd_ready
//   Flush side    : flush_out, redirect_pc
//
// Modports:
//   master - the environment (ROB commit, predictor, fetch)
//   slave  - the reporter block itself
// ---------------------------------------------------------------------------
interface branch_commit_reporter_if #(
    parameter int ADDR_W = 32
);

    logic              cmt_en;
    logic [ADDR_W-1:0] cmt_pc;
    logic              cmt_pred_jump;
    logic              cmt_jump;
    logic [ADDR_W-1:0] cmt_target;
    logic              cmt_ready;

    logic              rob_in_en;
    logic [ADDR_W-1:0] rob_ain;
    logic              rob_jump;
    logic              upd_ready;

    logic              flush_out;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output cmt_en,
        output cmt_pc,
        output cmt_pred_jump,
        output cmt_jump,
        output cmt_target,
        input  cmt_ready,
        input  rob_in_en,
        input  rob_ain,
        input  rob_jump,
        output upd_ready,
        input  flush_out,
        input  redirect_pc
    );

    modport slave (
        input  cmt_en,
        input  cmt_pc,
        input  cmt_pred_jump,
        input  cmt_jump,
        input  cmt_target,
        output cmt_ready,
        output rob_in_en,
        output rob_ain,
        output rob_jump,
        input  upd_ready,
        output flush_out,
        output redirect_pc
    );

endinterface

// File: rtl/branch_commit_reporter_fifo.sv
// ---------------------------------------------------------------------------
// bcr_fifo
//
// Generic synchronous FIFO used to queue committed branch updates.
//
// Parameters:
//   WIDTH  entry width
//   DEPTH  number of entries, power of 2, at least 2
//
// Ports:
//   clk     system clock
//   rst_in  synchronous reset, active-low (empties the FIFO)
//   rdy_in  global ready; low freezes pointers, occupancy and storage
//   push    write din at the tail (ignored when full)
//   pop     advance the head (ignored when empty)
//   din     write data
//   dout    head entry (only meaningful when !empty)
//   full    occupancy == DEPTH
//   empty   occupancy == 0
// ---------------------------------------------------------------------------
module bcr_fifo
    import branch_commit_reporter_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int              PTR_W      = bcr_ptr_width(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic do_push;
    logic do_pop;

    // Full/empty come from the occupancy counter only, so a same-cycle pop
    // never opens room for a push into a full FIFO.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full  && rdy_in;
    assign do_pop  = pop  && !empty && rdy_in;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH because DEPTH is a power of 2; the
    // extra counter bit is what separates full from empty.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (rst_in && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/branch_commit_reporter.sv
// ---------------------------------------------------------------------------
// branch_commit_reporter
//
// Sits between ROB commit and the branch predictor. Each committed
// conditional branch is queued as {pc, resolved direction} and drained into
// the predictor update port one entry per cycle. A direction mispredict on
// an accepted commit raises a one-cycle flush with the corrected fetch PC.
//
// Parameters:
//   ADDR_W  PC / address width
//   QDEPTH  update FIFO depth, power of 2, at least 2
//   CNT_W   statistics counter width (only with BRANCH_COMMIT_STATS_EN)
//
// Ports:
//   clk            system clock
//   rst_in         synchronous reset, active-low
//   rdy_in         global ready; low freezes all state and outputs
//   bus (slave)    commit inputs, cmt_ready, predictor update port
//                  (rob_in_en / rob_ain / rob_jump / upd_ready),
//                  flush_out and redirect_pc
//   stat_branches  accepted commits (BRANCH_COMMIT_STATS_EN only)
//   stat_mispred   accepted mispredicted commits (BRANCH_COMMIT_STATS_EN only)
//
// Optional feature macro: BRANCH_COMMIT_STATS_EN adds saturating counters.
// ---------------------------------------------------------------------------
module branch_commit_reporter
    import branch_commit_reporter_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int QDEPTH = BCR_QDEPTH
`ifdef BRANCH_COMMIT_STATS_EN
   ,parameter int CNT_W  = BCR_CNT_WIDTH
`endif
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    branch_commit_reporter_if.slave    bus
`ifdef BRANCH_COMMIT_STATS_EN
   ,output logic [CNT_W-1:0]           stat_branches,
    output logic [CNT_W-1:0]           stat_mispred
`endif
);

    localparam int ENTRY_W = bcr_entry_width(ADDR_W);

    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;

    logic               cmt_accept;
    logic               upd_accept;
    logic               mispredict;
    logic [ADDR_W-1:0]  fallthrough_pc;
    logic [ADDR_W-1:0]  corrected_pc;

    // Handshakes: a commit is taken only with room in the FIFO, an update
    // retires only when the predictor takes it, and both stall on rdy_in.
    assign cmt_accept = bus.cmt_en && !fifo_full && rdy_in;
    assign upd_accept = !fifo_empty && bus.upd_ready && rdy_in;
    assign mispredict = bcr_is_mispredict(bus.cmt_pred_jump, bus.cmt_jump);

    // Pack {pc, jump} using the shared field positions.
    always_comb begin
        fifo_din                                    = '0;
        fifo_din[BCR_ENTRY_JUMP_BIT]                = bus.cmt_jump;
        fifo_din[BCR_ENTRY_PC_LSB +: ADDR_W]        = bus.cmt_pc;
    end

    bcr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .push   (cmt_accept),
        .pop    (upd_accept),
        .din    (fifo_din),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // The head is forced to zero while empty so the update port reads as
    // all-zero after reset instead of exposing stale storage.
    assign bus.cmt_ready = !fifo_full;
    assign bus.rob_in_en = !fifo_empty;
    assign bus.rob_ain   = fifo_empty ? '0
                                      : fifo_dout[BCR_ENTRY_PC_LSB +: ADDR_W];
    assign bus.rob_jump  = fifo_empty ? 1'b0
                                      : fifo_dout[BCR_ENTRY_JUMP_BIT];

    // Taken branches resume at the resolved target, not-taken ones at the
    // next sequential instruction; the add wraps at 2^ADDR_W.
    assign fallthrough_pc = bus.cmt_pc + ADDR_W'(4);
    assign corrected_pc   = bus.cmt_jump ? bus.cmt_target : fallthrough_pc;

    // Flush is a registered one-cycle pulse. redirect_pc only loads on a
    // mispredict so it keeps the last corrected PC afterwards. The FIFO is
    // intentionally left alone: queued entries are committed and still need
    // to train the predictor.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            bus.flush_out   <= 1'b0;
            bus.redirect_pc <= '0;
        end else if (rdy_in) begin
            bus.flush_out <= cmt_accept && mispredict;
            if (cmt_accept && mispredict) begin
                bus.redirect_pc <= corrected_pc;
            end
        end
    end

`ifdef BRANCH_COMMIT_STATS_EN
    // Saturating statistics; they stop at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (rdy_in && cmt_accept) begin
            if (stat_branches != '1) begin
                stat_branches <= stat_branches + 1'b1;
            end
            if (mispredict && (stat_mispred != '1)) begin
                stat_mispred <= stat_mispred + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_commit_reporter.sv
// ---------------------------------------------------------------------------
// tb_branch_commit_reporter
//
// Directed and randomized stimulus for branch_commit_reporter. Expected
// outputs come from a queue-based reference model updated at every rising
// edge; outputs are sampled on the falling edge.
// Optional feature macro: BRANCH_COMMIT_STATS_EN
// ---------------------------------------------------------------------------
module tb_branch_commit_reporter;

    localparam int ADDR_W = 32;
    localparam int QDEPTH = 4;
`ifdef BRANCH_COMMIT_STATS_EN
    localparam int CNT_W  = 32;
`endif

    logic clk = 1'b0;
    logic rst_in;
    logic rdy_in;

    always #5 clk = ~clk;

    branch_commit_reporter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef BRANCH_COMMIT_STATS_EN
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispred;
`endif

    branch_commit_reporter #(
        .ADDR_W (ADDR_W),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .bus           (bus)
`ifdef BRANCH_COMMIT_STATS_EN
       ,.stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    // Reference model state.
    typedef struct {
        logic [31:0] pc;
        logic        jump;
    } upd_t;

    upd_t        mq[$];
    logic        exp_flush;
    logic [31:0] exp_redirect;
    longint      exp_branches;
    longint      exp_mispred;

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst_n, input logic rdy,
                                 input logic en, input logic [31:0] pc,
                                 input logic pred, input logic jump,
                                 input logic [31:0] target, input logic upd);
        rst_in            = rst_n;
        rdy_in            = rdy;
        bus.cmt_en        = en;
        bus.cmt_pc        = pc;
        bus.cmt_pred_jump = pred;
        bus.cmt_jump      = jump;
        bus.cmt_target    = target;
        bus.upd_ready     = upd;
    endtask

    // Model of one rising edge, written from the block's rules.
    task automatic modelEdge();
        bit   acc;
        bit   pop;
        upd_t e;
        if (!rst_in) begin
            mq.delete();
            exp_flush    = 1'b0;
            exp_redirect = 32'h0;
            exp_branches = 0;
            exp_mispred  = 0;
        end else if (rdy_in) begin
            acc = bus.cmt_en && (mq.size() < QDEPTH);
            pop = (mq.size() > 0) && bus.upd_ready;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                e.pc   = bus.cmt_pc;
                e.jump = bus.cmt_jump;
                mq.push_back(e);
                exp_branches++;
                if (bus.cmt_pred_jump != bus.cmt_jump) exp_mispred++;
            end
            exp_flush = acc && (bus.cmt_pred_jump != bus.cmt_jump);
            if (exp_flush)
                exp_redirect = bus.cmt_jump ? bus.cmt_target : bus.cmt_pc + 32'd4;
        end
    endtask

    task automatic checkAll();
        logic [31:0] head_pc;
        logic        head_jump;
        head_pc   = (mq.size() > 0) ? mq[0].pc   : 32'h0;
        head_jump = (mq.size() > 0) ? mq[0].jump : 1'b0;
        checkOutput("cmt_ready",   64'(bus.cmt_ready),   64'(mq.size() < QDEPTH));
        checkOutput("rob_in_en",   64'(bus.rob_in_en),   64'(mq.size() > 0));
        checkOutput("rob_ain",     64'(bus.rob_ain),     64'(head_pc));
        checkOutput("rob_jump",    64'(bus.rob_jump),    64'(head_jump));
        checkOutput("flush_out",   64'(bus.flush_out),   64'(exp_flush));
        checkOutput("redirect_pc", 64'(bus.redirect_pc), 64'(exp_redirect));
`ifdef BRANCH_COMMIT_STATS_EN
        checkOutput("stat_branches", 64'(stat_branches), 64'(exp_branches));
        checkOutput("stat_mispred",  64'(stat_mispred),  64'(exp_mispred));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    task automatic step(input logic rst_n, input logic rdy, input logic en,
                        input logic [31:0] pc, input logic pred,
                        input logic jump, input logic [31:0] target,
                        input logic upd);
        applyStimulus(rst_n, rdy, en, pc, pred, jump, target, upd);
        tick();
    endtask

    task automatic idle(input logic upd);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, upd);
    endtask

    initial begin
        $display("[TB] start");

        // Reset
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("reset_cmt_ready", 64'(bus.cmt_ready), 64'd1);
        checkOutput("reset_rob_in_en", 64'(bus.rob_in_en), 64'd0);

        // Single correctly predicted commit, then it drains
        step(1'b1, 1'b1, 1'b1, 32'h1000, 1'b1, 1'b1, 32'h5000, 1'b1);
        checkOutput("single_ain",   64'(bus.rob_ain),   64'h1000);
        checkOutput("single_jump",  64'(bus.rob_jump),  64'd1);
        checkOutput("single_flush", 64'(bus.flush_out), 64'd0);
        idle(1'b1);
        checkOutput("single_drained", 64'(bus.rob_in_en), 64'd0);

        // Mispredicts: not-taken fallthrough, taken target, wrap at 2^32
        step(1'b1, 1'b1, 1'b1, 32'h2000, 1'b1, 1'b0, 32'h3000, 1'b1);
        checkOutput("mp_nt_flush", 64'(bus.flush_out),   64'd1);
        checkOutput("mp_nt_pc",    64'(bus.redirect_pc), 64'h2004);
        idle(1'b1);
        checkOutput("mp_pulse_end", 64'(bus.flush_out),   64'd0);
        checkOutput("mp_pc_hold",   64'(bus.redirect_pc), 64'h2004);
        step(1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1, 32'h3000, 1'b1);
        checkOutput("mp_t_pc", 64'(bus.redirect_pc), 64'h3000);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h3000, 1'b1);
        checkOutput("mp_wrap_pc",    64'(bus.redirect_pc), 64'h0);
        checkOutput("mp_b2b_flush",  64'(bus.flush_out),   64'd1);
        idle(1'b1);
        idle(1'b1);

        // Fill with the predictor stalled, fifth commit refused, then drain
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b1, 32'h100 * (i + 1), 1'b0, i[0], 32'h0, 1'b0);
        checkOutput("fill_not_ready", 64'(bus.cmt_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("fill_order", 64'(bus.rob_ain), 64'(32'h100 * (i + 1)));
            idle(1'b1);
        end
        checkOutput("fill_empty", 64'(bus.rob_in_en), 64'd0);

        // Freeze with two entries queued and a pending flush
        step(1'b1, 1'b1, 1'b1, 32'h4000, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h4100, 1'b0, 1'b1, 32'h4800, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b1, 32'h9000, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("freeze_flush_hold", 64'(bus.flush_out), 64'd1);
        checkOutput("freeze_head",       64'(bus.rob_ain),   64'h4000);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset mid-operation with entries queued and a flush pending
        step(1'b1, 1'b1, 1'b1, 32'h5000, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h5100, 1'b1, 1'b1, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h5200, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_mid_in_en", 64'(bus.rob_in_en), 64'd0);
        checkOutput("rst_mid_flush", 64'(bus.flush_out), 64'd0);
        checkOutput("rst_mid_ready", 64'(bus.cmt_ready), 64'd1);

        // Six commits, two of them mispredicted
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b1, 32'h6000 + 32'(i * 4), 1'b1,
                 (i == 1 || i == 4) ? 1'b0 : 1'b1, 32'h7000, 1'b1);
`ifdef BRANCH_COMMIT_STATS_EN
        checkOutput("stats_branches", 64'(stat_branches), 64'd6);
        checkOutput("stats_mispred",  64'(stat_mispred),  64'd2);
`endif
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                              : ($urandom() & 32'hFFFF_FFFC);
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 70),
                 pc,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom() & 32'hFFFF_FFFC,
                 ($urandom_range(0, 99) < 60));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
